// File: rtl/bit_counter_win.sv
// rtl/bit_counter_win.sv - prescaled up/down counter with wrap/saturate, terminal-count pulse,
// sticky wrap flag and a selectable SLICE-wide LED window onto the count.
module bit_counter_win #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8,
  parameter int DIV   = 1,
  localparam int NWIN = WIDTH / SLICE,
  localparam int SELW = (NWIN > 1) ? $clog2(NWIN) : 1,
  localparam int PW   = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flag,
  input  logic [SELW-1:0]  sel,
  output logic [WIDTH-1:0] q,
  output logic [SLICE-1:0] led,
  output logic             tc,
  output logic             wrapped
);

  logic [WIDTH-1:0] r_q;
  logic [PW-1:0]    r_pre;
  logic             r_tc;
  logic             r_wrapped;

  logic             w_tick;
  logic             w_at_term;
  logic             w_event;
  logic [WIDTH-1:0] w_term;
  logic [WIDTH-1:0] w_next;
  logic [SLICE-1:0] w_led;

  assign w_tick    = en & (r_pre == PW'(DIV - 1));
  assign w_term    = up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
  assign w_at_term = (r_q == w_term);
  // A load in the same cycle suppresses the event even if a tick lines up.
  assign w_event   = w_tick & w_at_term & ~load;

  always_comb begin
    w_next = r_q;
    if (w_at_term) begin
      if (!sat) w_next = up ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
    end else begin
      w_next = up ? (r_q + WIDTH'(1)) : (r_q - WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q       <= '0;
      r_pre     <= '0;
      r_tc      <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      if (load) begin
        r_q   <= load_val;
        r_pre <= '0;
      end else if (en) begin
        if (w_tick) begin
          r_q   <= w_next;
          r_pre <= '0;
        end else begin
          r_pre <= r_pre + PW'(1);
        end
      end
      r_tc      <= w_event;
      r_wrapped <= w_event | (r_wrapped & ~clr_flag);
    end
  end

  // Out-of-range selects fall through to the all-zero default.
  always_comb begin
    w_led = '0;
    for (int i = 0; i < NWIN; i++) begin
      if (sel == SELW'(i)) w_led = r_q[i*SLICE +: SLICE];
    end
  end

  assign q       = r_q;
  assign led     = w_led;
  assign tc      = r_tc;
  assign wrapped = r_wrapped;

endmodule
